// File: rtl/alu_cmd_deframer.sv
// -----------------------------------------------------------------------------
// alu_cmd_deframer
//
// Byte-stream command parser between the UART receiver and alu32. It hunts for
// a sync byte, then assembles an opcode byte and two little-endian operands.
// The finished command is presented to the ALU over a valid/ready handshake.
//
// Build option:
//   ALU_CMD_CHECKSUM_EN - when defined, a checksum byte follows operand B. It
//                         must equal the XOR of the opcode byte and all operand
//                         bytes, otherwise the frame is dropped with error_o.
//
// Ports:
//   clk_i        in   1        clock
//   reset_i      in   1        asynchronous active-high reset
//   valid_i      in   1        byte valid from UART receiver
//   data_i       in   8        received byte
//   ready_o      out  1        byte accepted this cycle when valid_i is high
//   ready_i      in   1        ALU ready to take the command
//   valid_o      out  1        command valid to ALU
//   opcode_o     out  2        0 Nop, 1 Add, 2 Mul, 3 Div
//   operand_a_o  out  width_p  operand A
//   operand_b_o  out  width_p  operand B
//   error_o      out  1        one-cycle pulse when a frame is dropped
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_SYNC   | discard bytes until the sync byte arrives
// ST_OPCODE | next byte is the opcode; upper six bits must be zero
// ST_OPER_A | collect NB bytes of operand A, LSB first
// ST_OPER_B | collect NB bytes of operand B, LSB first
// ST_CHECK  | (checksum build only) compare received byte with running XOR
// ST_ISSUE  | hold command on the ALU interface until ready_i
// -----------------------------------------------------------------------------
module alu_cmd_deframer #(
  parameter logic [7:0] sync_byte_p = 8'hA5,
  parameter int         width_p     = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [7:0]         data_i,
  output logic               ready_o,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [1:0]         opcode_o,
  output logic [width_p-1:0] operand_a_o,
  output logic [width_p-1:0] operand_b_o,
  output logic               error_o
);

  localparam int NB    = width_p / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

`ifdef ALU_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_SYNC, ST_OPCODE, ST_OPER_A, ST_OPER_B, ST_CHECK, ST_ISSUE
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_SYNC, ST_OPCODE, ST_OPER_A, ST_OPER_B, ST_ISSUE
  } state_t;
`endif

  state_t             r_state;
  state_t             w_state_next;
  logic               w_error_next;
  logic               w_accept;
  logic               w_cnt_last;
  logic               w_op_ok;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_opcode;
  logic [width_p-1:0] r_oper_a;
  logic [width_p-1:0] r_oper_b;
  logic               r_error;
`ifdef ALU_CMD_CHECKSUM_EN
  logic [7:0]         r_xor;
`endif

  assign ready_o     = (r_state != ST_ISSUE);
  assign valid_o     = (r_state == ST_ISSUE);
  assign opcode_o    = r_opcode;
  assign operand_a_o = r_oper_a;
  assign operand_b_o = r_oper_b;
  assign error_o     = r_error;

  assign w_accept   = valid_i && ready_o;
  assign w_cnt_last = (r_cnt == CNT_W'(NB - 1));
  assign w_op_ok    = (data_i[7:2] == 6'd0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_error_next = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_accept && (data_i == sync_byte_p)) w_state_next = ST_OPCODE;
      end
      ST_OPCODE: begin
        if (w_accept) begin
          if (w_op_ok) begin
            w_state_next = ST_OPER_A;
          end else begin
            w_state_next = ST_SYNC;
            w_error_next = 1'b1;
          end
        end
      end
      ST_OPER_A: begin
        if (w_accept && w_cnt_last) w_state_next = ST_OPER_B;
      end
      ST_OPER_B: begin
`ifdef ALU_CMD_CHECKSUM_EN
        if (w_accept && w_cnt_last) w_state_next = ST_CHECK;
`else
        if (w_accept && w_cnt_last) w_state_next = ST_ISSUE;
`endif
      end
`ifdef ALU_CMD_CHECKSUM_EN
      ST_CHECK: begin
        if (w_accept) begin
          if (data_i == r_xor) begin
            w_state_next = ST_ISSUE;
          end else begin
            w_state_next = ST_SYNC;
            w_error_next = 1'b1;
          end
        end
      end
`endif
      ST_ISSUE: begin
        if (ready_i) w_state_next = ST_SYNC;
      end
      default: w_state_next = ST_SYNC;
    endcase
  end

  // Datapath: operands are overwritten positionally, so no clearing is needed
  // between frames; every byte of both operands is rewritten by a full frame.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt    <= '0;
      r_opcode <= 2'd0;
      r_oper_a <= '0;
      r_oper_b <= '0;
      r_error  <= 1'b0;
`ifdef ALU_CMD_CHECKSUM_EN
      r_xor    <= 8'd0;
`endif
    end else begin
      r_error <= w_error_next;
      case (r_state)
        ST_OPCODE: begin
          if (w_accept && w_op_ok) begin
            r_opcode <= data_i[1:0];
            r_cnt    <= '0;
`ifdef ALU_CMD_CHECKSUM_EN
            r_xor    <= data_i;
`endif
          end
        end
        ST_OPER_A: begin
          if (w_accept) begin
            r_oper_a[8*r_cnt +: 8] <= data_i;
            r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
`ifdef ALU_CMD_CHECKSUM_EN
            r_xor <= r_xor ^ data_i;
`endif
          end
        end
        ST_OPER_B: begin
          if (w_accept) begin
            r_oper_b[8*r_cnt +: 8] <= data_i;
            r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
`ifdef ALU_CMD_CHECKSUM_EN
            r_xor <= r_xor ^ data_i;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
